// File: rtl/emif_axi_mm_responder.sv
// emif_axi_mm_responder: AXI4 memory-mapped slave backed by an internal word array,
// INCR full-width bursts only; anything else is drained and answered with SLVERR.
module emif_axi_mm_responder #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 8,
  parameter int USER_WIDTH = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [LEN_WIDTH-1:0]    awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic [USER_WIDTH-1:0]   awuser,
  input  logic                    awlock,
  input  logic [3:0]              awcache,
  input  logic [2:0]              awprot,
  input  logic [3:0]              awqos,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic [USER_WIDTH-1:0]   wuser,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic [USER_WIDTH-1:0]   buser,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [LEN_WIDTH-1:0]    arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic [USER_WIDTH-1:0]   aruser,
  input  logic                    arlock,
  input  logic [3:0]              arcache,
  input  logic [2:0]              arprot,
  input  logic [3:0]              arqos,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic [USER_WIDTH-1:0]   ruser
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int B  = $clog2(SW);
  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef logic [LEN_WIDTH-1:0] cnt_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic init_q;
  w_state_t w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] w_id_q, w_id_d, r_id_q, r_id_d;
  logic [USER_WIDTH-1:0] w_user_q, w_user_d, r_user_q, r_user_d;
  cnt_t w_len_q, w_len_d, w_cnt_q, w_cnt_d, r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  idx_t w_idx_q, w_idx_d, r_idx_q, r_idx_d, ar_idx, r_next_idx;
  logic w_ill_q, w_ill_d, w_err_q, w_err_d, r_ill_q, r_ill_d, ar_ill;
  r_state_t r_state_q, r_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic w_fire, w_final, r_fire, r_final;
  logic unused;
  assign unused = ^{awlock, awcache, awprot, awqos, arlock, arcache, arprot, arqos, wuser, awaddr, araddr};
  always_comb begin
    awready = init_q && w_state_q == W_IDLE;
    wready  = w_state_q == W_DATA;
    bvalid  = w_state_q == W_RESP;
    bid     = w_id_q;
    buser   = w_user_q;
    bresp   = bvalid && (w_ill_q || w_err_q) ? 2'b10 : 2'b00;
    w_fire  = wvalid && wready;
    w_final = w_cnt_q == w_len_q;
    w_state_d = w_state_q;
    w_id_d = w_id_q;
    w_user_d = w_user_q;
    w_len_d = w_len_q;
    w_cnt_d = w_cnt_q;
    w_idx_d = w_idx_q;
    w_ill_d = w_ill_q;
    w_err_d = w_err_q;
    if (awvalid && awready) begin
      w_state_d = W_DATA;
      w_id_d = awid;
      w_user_d = awuser;
      w_len_d = awlen;
      w_cnt_d = '0;
      w_idx_d = awaddr[B+DEPTH_LOG2-1:B];
      w_ill_d = !(awburst == 2'b01 && awsize == 3'(B));
      w_err_d = 1'b0;
    end
    if (w_fire) begin
      w_err_d = w_err_q || (wlast != w_final);
      w_cnt_d = w_cnt_q + cnt_t'(1);
      w_idx_d = w_idx_q + idx_t'(1);
      w_state_d = w_final ? W_RESP : W_DATA;
    end
    if (bvalid && bready) w_state_d = W_IDLE;
  end
  // Read data is registered when a beat is presented, so it holds through stalls
  // and a write landing on the same edge only shows up at the next presentation.
  always_comb begin
    arready = init_q && r_state_q == R_IDLE;
    rvalid  = r_state_q == R_DATA;
    rid     = r_id_q;
    ruser   = r_user_q;
    rdata   = rdata_q;
    r_final = r_cnt_q == r_len_q;
    rlast   = rvalid && r_final;
    rresp   = rvalid && r_ill_q ? 2'b10 : 2'b00;
    r_fire  = rvalid && rready;
    ar_idx  = araddr[B+DEPTH_LOG2-1:B];
    ar_ill  = !(arburst == 2'b01 && arsize == 3'(B));
    r_next_idx = r_idx_q + idx_t'(1);
    r_state_d = r_state_q;
    r_id_d = r_id_q;
    r_user_d = r_user_q;
    r_len_d = r_len_q;
    r_cnt_d = r_cnt_q;
    r_idx_d = r_idx_q;
    r_ill_d = r_ill_q;
    rdata_d = rdata_q;
    if (arvalid && arready) begin
      r_state_d = R_DATA;
      r_id_d = arid;
      r_user_d = aruser;
      r_len_d = arlen;
      r_cnt_d = '0;
      r_idx_d = ar_idx;
      r_ill_d = ar_ill;
      rdata_d = ar_ill ? '0 : mem[ar_idx];
    end
    if (r_fire && r_final) r_state_d = R_IDLE;
    if (r_fire && !r_final) begin
      r_cnt_d = r_cnt_q + cnt_t'(1);
      r_idx_d = r_next_idx;
      rdata_d = r_ill_q ? '0 : mem[r_next_idx];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b0;
      w_state_q <= W_IDLE;
      w_id_q <= '0;
      w_user_q <= '0;
      w_len_q <= '0;
      w_cnt_q <= '0;
      w_idx_q <= '0;
      w_ill_q <= 1'b0;
      w_err_q <= 1'b0;
      r_state_q <= R_IDLE;
      r_id_q <= '0;
      r_user_q <= '0;
      r_len_q <= '0;
      r_cnt_q <= '0;
      r_idx_q <= '0;
      r_ill_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      init_q <= 1'b1;
      w_state_q <= w_state_d;
      w_id_q <= w_id_d;
      w_user_q <= w_user_d;
      w_len_q <= w_len_d;
      w_cnt_q <= w_cnt_d;
      w_idx_q <= w_idx_d;
      w_ill_q <= w_ill_d;
      w_err_q <= w_err_d;
      r_state_q <= r_state_d;
      r_id_q <= r_id_d;
      r_user_q <= r_user_d;
      r_len_q <= r_len_d;
      r_cnt_q <= r_cnt_d;
      r_idx_q <= r_idx_d;
      r_ill_q <= r_ill_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (w_fire && !w_ill_q)
      for (int i = 0; i < SW; i++)
        if (wstrb[i]) mem[w_idx_q][i*8 +: 8] <= wdata[i*8 +: 8];
  end
endmodule

// File: tb/tb_emif_axi_mm_responder.sv
// tb_emif_axi_mm_responder: directed vectors for the AXI memory responder
// with hand-computed expectations.
module tb_emif_axi_mm_responder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic awvalid = 0, awlock = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, arlock = 0, rready = 0;
  logic [7:0] awid = 0, arid = 0, awlen = 0, arlen = 0;
  logic [31:0] awaddr = 0, araddr = 0;
  logic [2:0] awsize = 0, arsize = 0, awprot = 0, arprot = 0;
  logic [1:0] awburst = 0, arburst = 0;
  logic [3:0] awuser = 0, aruser = 0, wuser = 0, awcache = 0, awqos = 0, arcache = 0, arqos = 0;
  logic [511:0] wdata = 0;
  logic [63:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [7:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [3:0] buser, ruser;
  logic [511:0] rdata;
  int n_cmp = 0, n_err = 0;
  emif_axi_mm_responder dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awuser(awuser), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awqos(awqos),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp), .buser(buser),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .aruser(aruser), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arqos(arqos),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .ruser(ruser)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [511:0] pat(input logic [31:0] s);
    return {16{s}};
  endfunction
  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    awvalid = 1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awuser = 4'h9;
    for (int n = 0; n < 20 && !awready; n++) step();
    check("awready", awready, 1);
    step();
    awvalid = 0;
  endtask
  task automatic w_beat(input logic [511:0] d, input logic [63:0] s, input logic l);
    wvalid = 1; wdata = d; wstrb = s; wlast = l;
    for (int n = 0; n < 20 && !wready; n++) step();
    check("wready", wready, 1);
    step();
    wvalid = 0;
  endtask
  task automatic b_get(input string tag, input logic [1:0] resp, input logic [7:0] id);
    bready = 1;
    for (int n = 0; n < 20 && !bvalid; n++) step();
    check({tag, ".bvalid"}, bvalid, 1);
    check({tag, ".bresp"}, bresp, resp);
    check({tag, ".bid"}, bid, id);
    check({tag, ".buser"}, buser, 4'h9);
    step();
    bready = 0;
  endtask
  task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    arvalid = 1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; aruser = 4'h6;
    for (int n = 0; n < 20 && !arready; n++) step();
    check("arready", arready, 1);
    step();
    arvalid = 0;
  endtask
  task automatic r_get(input string tag, input logic [511:0] d, input logic [1:0] resp,
                       input logic last, input logic [7:0] id);
    rready = 1;
    for (int n = 0; n < 20 && !rvalid; n++) step();
    check({tag, ".rvalid"}, rvalid, 1);
    check({tag, ".rdata"}, rdata, d);
    check({tag, ".rresp"}, rresp, resp);
    check({tag, ".rlast"}, rlast, last);
    check({tag, ".rid"}, rid, id);
    check({tag, ".ruser"}, ruser, 4'h6);
    step();
    rready = 0;
  endtask
  initial begin
    logic [511:0] d;
    step();
    step();
    check("rst.awready", awready, 0);
    check("rst.arready", arready, 0);
    check("rst.wready", wready, 0);
    check("rst.bvalid", bvalid, 0);
    check("rst.rvalid", rvalid, 0);
    check("rst.rdata", rdata, 0);
    check("rst.bresp", bresp, 0);
    rst_n = 1;
    #1;
    check("rel.awready_pre", awready, 0);
    step();
    check("rel.awready", awready, 1);
    check("rel.arready", arready, 1);
    aw_send(8'h5A, 32'h40, 3, 3'd6, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(pat(32'hD0D0_0000 + i), '1, i == 3);
    b_get("wr4", 2'b00, 8'h5A);
    ar_send(8'h33, 32'h40, 3, 3'd6, 2'b01);
    for (int i = 0; i < 4; i++) r_get("rd4", pat(32'hD0D0_0000 + i), 2'b00, i == 3, 8'h33);
    aw_send(8'h01, 32'h400, 0, 3'd6, 2'b01);
    w_beat('1, '1, 1);
    b_get("ff", 2'b00, 8'h01);
    aw_send(8'h02, 32'h400, 0, 3'd6, 2'b01);
    w_beat('0, 64'h1, 1);
    b_get("strb", 2'b00, 8'h02);
    ar_send(8'h03, 32'h400, 0, 3'd6, 2'b01);
    d = '1;
    d[7:0] = 8'h00;
    r_get("strb", d, 2'b00, 1, 8'h03);
    aw_send(8'h11, 32'h40, 1, 3'd6, 2'b10);
    w_beat('0, '1, 0);
    w_beat('0, '1, 1);
    b_get("wrap_burst", 2'b10, 8'h11);
    aw_send(8'h12, 32'h40, 0, 3'd5, 2'b01);
    w_beat('0, '1, 1);
    b_get("narrow", 2'b10, 8'h12);
    ar_send(8'h13, 32'h40, 0, 3'd6, 2'b01);
    r_get("unchanged", pat(32'hD0D0_0000), 2'b00, 1, 8'h13);
    ar_send(8'h14, 32'h40, 1, 3'd6, 2'b10);
    r_get("ill_rd0", '0, 2'b10, 0, 8'h14);
    r_get("ill_rd1", '0, 2'b10, 1, 8'h14);
    ar_send(8'h15, 32'h40, 0, 3'd2, 2'b01);
    r_get("ill_size", '0, 2'b10, 1, 8'h15);
    aw_send(8'h21, 32'hFFC0, 1, 3'd6, 2'b01);
    w_beat(pat(32'hE0E0_0000), '1, 0);
    w_beat(pat(32'hE0E0_0001), '1, 1);
    b_get("edge", 2'b00, 8'h21);
    ar_send(8'h22, 32'h0001_0000, 0, 3'd6, 2'b01);
    r_get("alias0", pat(32'hE0E0_0001), 2'b00, 1, 8'h22);
    ar_send(8'h23, 32'hFFC0, 1, 3'd6, 2'b01);
    r_get("wrap0", pat(32'hE0E0_0000), 2'b00, 0, 8'h23);
    r_get("wrap1", pat(32'hE0E0_0001), 2'b00, 1, 8'h23);
    aw_send(8'h24, 32'h800, 3, 3'd6, 2'b01);
    for (int i = 0; i < 4; i++) w_beat('0, '1, i == 0);
    b_get("early_last", 2'b10, 8'h24);
    aw_send(8'h25, 32'h800, 0, 3'd6, 2'b01);
    w_beat('0, '1, 0);
    b_get("no_last", 2'b10, 8'h25);
    ar_send(8'h31, 32'h40, 3, 3'd6, 2'b01);
    r_get("stall0", pat(32'hD0D0_0000), 2'b00, 0, 8'h31);
    for (int i = 0; i < 5; i++) begin
      check("stall.rdata", rdata, pat(32'hD0D0_0001));
      check("stall.rlast", rlast, 0);
      check("stall.rid", rid, 8'h31);
      step();
    end
    for (int i = 1; i < 4; i++) r_get("stall", pat(32'hD0D0_0000 + i), 2'b00, i == 3, 8'h31);
    awvalid = 1; awid = 8'h41; awaddr = 32'hC0; awlen = 0; awsize = 3'd6; awburst = 2'b01; awuser = 4'h9;
    arvalid = 1; arid = 8'h42; araddr = 32'h40; arlen = 0; arsize = 3'd6; arburst = 2'b01; aruser = 4'h6;
    check("conc.awready", awready, 1);
    check("conc.arready", arready, 1);
    step();
    awvalid = 0;
    arvalid = 0;
    check("conc.aw_busy", awready, 0);
    check("conc.ar_busy", arready, 0);
    r_get("conc", pat(32'hD0D0_0000), 2'b00, 1, 8'h42);
    w_beat(pat(32'hC0C0_C0C0), '1, 1);
    b_get("conc", 2'b00, 8'h41);
    ar_send(8'h51, 32'h40, 3, 3'd6, 2'b01);
    r_get("prerst", pat(32'hD0D0_0000), 2'b00, 0, 8'h51);
    check("prerst.rvalid", rvalid, 1);
    rst_n = 0;
    #1;
    check("midrst.rvalid", rvalid, 0);
    check("midrst.rlast", rlast, 0);
    check("midrst.rdata", rdata, 0);
    check("midrst.rid", rid, 0);
    step();
    check("midrst.arready", arready, 0);
    rst_n = 1;
    step();
    check("postrst.arready", arready, 1);
    check("postrst.rvalid", rvalid, 0);
    step();
    check("postrst.stale", rvalid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/emif_axi_mm_responder.md
EMIF_AXI_MM_RESPONDER -- requirements
Module: emif_axi_mm_responder

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  ID_WIDTH, 8, AXI awid/arid/bid/rid width
  ADDR_WIDTH, 32, awaddr/araddr width
  DATA_WIDTH, 512, wdata/rdata width; power of 2, >= 16
  LEN_WIDTH, 8, awlen/arlen width
  USER_WIDTH, 4, awuser/aruser/wuser/buser/ruser width
  DEPTH_LOG2, 10, log2 of internal memory word count
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk, in, 1, sole clock
  rst_n, in, 1, asynchronous active-low reset
  awvalid/awready, in/out, 1/1, write-address handshake
  awid/awaddr/awlen/awsize/awburst/awuser, in, ID/ADDR/LEN/3/2/USER, write-address payload
  awlock/awcache/awprot/awqos, in, 1/4/3/4, accepted and ignored
  wvalid/wready, in/out, 1/1, write-data handshake
  wdata/wstrb/wlast/wuser, in, DATA/DATA/8/1/USER, write beat; wuser ignored
  bvalid/bready, out/in, 1/1, write-response handshake
  bid/bresp/buser, out, ID/2/USER, write response
  arvalid/arready, in/out, 1/1, read-address handshake
  arid/araddr/arlen/arsize/arburst/aruser, in, ID/ADDR/LEN/3/2/USER, read-address payload
  arlock/arcache/arprot/arqos, in, 1/4/3/4, accepted and ignored
  rvalid/rready, out/in, 1/1, read-data handshake
  rid/rdata/rresp/rlast/ruser, out, ID/DATA/2/1/USER, read beat
REQ-003 SHALL use one clock, clk; reset SHALL be asynchronous and active-low, rst_n.

Function
REQ-004 SHALL hold 2^DEPTH_LOG2 words of DATA_WIDTH; word index = addr[B+DEPTH_LOG2-1:B], B=log2(DATA_WIDTH/8); upper bits ignored (aliasing); memory contents not reset.
REQ-005 Request legal iff burst==2'b01 (INCR) and size==B; beat n index = (start+n) mod 2^DEPTH_LOG2 (wraps).
REQ-006 Write FSM states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; AW handshake captures id/addr/len/user, beat count=0, ->W_DATA.
REQ-007 W_DATA: wready=1; each wvalid&&wready beat writes bytes with wstrb[i]=1 at that clock edge if legal (no write if illegal); after beat awlen+1 ->W_RESP regardless of wlast.
REQ-008 Protocol-error flag set if wlast=1 on a non-final beat or wlast=0 on final beat.
REQ-009 W_RESP: bvalid=1, bid=captured awid, buser=captured awuser, bresp=2'b10 (SLVERR) if illegal or error flag else 2'b00; bvalid&&bready ->W_IDLE; bvalid stable until accepted.
REQ-010 Read FSM states R_IDLE, R_DATA; arready=1 only in R_IDLE; AR handshake captures request, ->R_DATA; first rvalid one cycle after handshake.
REQ-011 R_DATA: rvalid=1, rdata=mem[current index] (0 if illegal), rid/ruser=captured, rresp=2'b10 if illegal else 2'b00, rlast=1 on beat arlen; beat advances on rvalid&&rready; payload stable while rvalid&&!rready.
REQ-012 After last beat accepted ->R_IDLE; next AR accepted no earlier than following cycle (min 1 idle cycle between bursts).
REQ-013 Read/write channels independent and concurrent; read beat reflects all writes completed at earlier edges; same-edge write to presented word not visible until next beat presentation.
REQ-014 Max burst length 2^LEN_WIDTH beats; awlen=arlen=0 valid single beat.

Reset
REQ-015 On rst_n=0 (async, including mid-burst): FSMs ->W_IDLE/R_IDLE, awready=arready=0 while reset asserted, wready=bvalid=rvalid=rlast=0, bid/bresp/buser/rid/rresp/ruser/rdata=0, counters and error flag cleared.
REQ-016 awready and arready SHALL rise on the first clk edge after rst_n deasserts; in-flight bursts are dropped, no response issued.

Verification
REQ-017 Write awaddr=0x40, awlen=3, full wstrb, data D0..D3 -> bresp=00, bid=awid; read araddr=0x40, arlen=3 -> D0..D3, rlast on 4th beat only, rresp=00.
REQ-018 Partial strobe: write 0xFF.. then wstrb=0x1 with 0x00.. at same word -> readback byte0=0x00, other bytes 0xFF.
REQ-019 awburst=2'b10 or awsize<B -> all beats accepted, memory unchanged, bresp=10; same on AR -> rresp=10 every beat, rdata=0.
REQ-020 Burst starting at index 2^DEPTH_LOG2-1, len=1 -> second beat lands at index 0; wlast on beat 0 of len=3 -> bresp=10.
REQ-021 rready held low 5 cycles mid-burst -> rdata/rid/rlast stable; concurrent AW/AR each accepted in same cycle.
REQ-022 rst_n asserted mid-read burst -> rvalid=0 immediately; after release arready=1 next edge, no stale beats.
